// File: rtl/screen_rom_arbiter.sv
// screen_rom_arbiter: two-requester round-robin arbiter with lock onto a shared synchronous ROM
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req0/1, lock0/1     read request and grant-hold request per requester
//   addr0/1             read address per requester
//   gnt0/1              combinational grant for the current cycle
//   dout0/1, vld0/1     registered read data and one-cycle valid pulse, two cycles after grant
//   rom_addr, rom_dout  shared ROM port (one-cycle read latency)
module screen_rom_arbiter #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  vld0,
  output logic                  vld1,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state;
  logic last, held, t1_vld, t1_id, hold0, hold1;
  logic [ADDR_WIDTH-1:0] addr_q;
  // held marks that the current owner asked to keep the grant; it only sticks while the owner still requests
  always_comb begin
    hold0 = state == OWN0 && held && req0;
    hold1 = state == OWN1 && held && req1;
    gnt0 = !rst && (hold0 || (!hold1 && req0 && (!req1 || last)));
    gnt1 = !rst && (hold1 || (!hold0 && req1 && (!req0 || !last)));
    rom_addr = gnt0 ? addr0 : gnt1 ? addr1 : addr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      held <= 1'b0;
      addr_q <= '0;
      t1_vld <= 1'b0;
      t1_id <= 1'b0;
      vld0 <= 1'b0;
      vld1 <= 1'b0;
      dout0 <= '0;
      dout1 <= '0;
    end else begin
      state <= gnt0 ? OWN0 : gnt1 ? OWN1 : IDLE;
      held <= (gnt0 && lock0) || (gnt1 && lock1);
      if (gnt0 || gnt1) begin
        last <= gnt1;
        addr_q <= rom_addr;
      end
      t1_vld <= gnt0 || gnt1;
      t1_id <= gnt1;
      vld0 <= t1_vld && !t1_id;
      vld1 <= t1_vld && t1_id;
      if (t1_vld && !t1_id) dout0 <= rom_dout;
      if (t1_vld && t1_id) dout1 <= rom_dout;
    end
  end
endmodule

// File: tb/tb_screen_rom_arbiter.sv
// tb_screen_rom_arbiter: randomized and directed check of screen_rom_arbiter against a behavioural model
module tb_screen_rom_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [19:0] addr0 = '0, addr1 = '0, rom_addr;
  logic gnt0, gnt1, vld0, vld1;
  logic [11:0] dout0, dout1, rom_dout = '0;
  int tests = 0, fails = 0;
  int m_last = 1, m_lock = -1;
  int hid [2] = '{-1, -1};
  logic [19:0] haddr [2] = '{20'h0, 20'h0};
  logic [19:0] e_raddr = '0;
  logic [11:0] e_d0 = '0, e_d1 = '0;

  screen_rom_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .gnt0(gnt0), .gnt1(gnt1), .dout0(dout0), .dout1(dout1),
    .vld0(vld0), .vld1(vld1), .rom_addr(rom_addr), .rom_dout(rom_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_f(input logic [19:0] a);
    return 12'(a[11:0] * 12'd3) ^ a[19:8];
  endfunction

  always @(posedge clk) rom_dout <= rom_f(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input logic r0, input logic r1, input logic l0, input logic l1,
                     input logic [19:0] a0, input logic [19:0] a1, input logic rs);
    int g;
    req0 = r0; req1 = r1; lock0 = l0; lock1 = l1; addr0 = a0; addr1 = a1; rst = rs;
    @(negedge clk);
    g = -1;
    if (rs) begin
      m_last = 1; m_lock = -1; hid = '{-1, -1}; e_raddr = '0; e_d0 = '0; e_d1 = '0;
    end else begin
      if (m_lock >= 0 && (m_lock == 0 ? r0 : r1)) g = m_lock;
      else if (r0 && r1) g = 1 - m_last;
      else if (r0) g = 0;
      else if (r1) g = 1;
      if (hid[1] == 0) e_d0 = rom_f(haddr[1]);
      if (hid[1] == 1) e_d1 = rom_f(haddr[1]);
      if (g >= 0) e_raddr = (g == 0) ? a0 : a1;
    end
    chk("gnt0", 32'(gnt0), 32'(g == 0));
    chk("gnt1", 32'(gnt1), 32'(g == 1));
    chk("rom_addr", 32'(rom_addr), 32'(e_raddr));
    chk("vld0", 32'(vld0), 32'(hid[1] == 0));
    chk("vld1", 32'(vld1), 32'(hid[1] == 1));
    chk("dout0", 32'(dout0), 32'(e_d0));
    chk("dout1", 32'(dout1), 32'(e_d1));
    if (!rs) begin
      hid[1] = hid[0]; haddr[1] = haddr[0];
      hid[0] = g; haddr[0] = e_raddr;
      if (g >= 0) begin
        m_last = g;
        m_lock = ((g == 0) ? l0 : l1) ? g : -1;
      end else m_lock = -1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    repeat (2) cyc(0, 0, 0, 0, 20'h0, 20'h0, 1);
    cyc(1, 0, 0, 0, 20'h00010, 20'h0, 0);
    repeat (3) cyc(0, 0, 0, 0, 20'h0, 20'h0, 0);
    repeat (6) cyc(1, 1, 0, 0, 20'($urandom), 20'($urandom), 0);
    repeat (2) cyc(0, 0, 0, 0, 20'h0, 20'h0, 0);
    cyc(0, 1, 0, 1, 20'h0, 20'h00abc, 0);
    repeat (3) cyc(1, 1, 0, 1, 20'($urandom), 20'($urandom), 0);
    repeat (3) cyc(1, 1, 0, 0, 20'($urandom), 20'($urandom), 0);
    cyc(1, 0, 1, 0, 20'h00123, 20'h0, 0);
    cyc(0, 1, 1, 0, 20'h00456, 20'h00789, 0);
    repeat (2) cyc(0, 0, 0, 0, 20'h0, 20'h0, 0);
    cyc(0, 1, 0, 0, 20'h0, 20'h00555, 0);
    cyc(0, 0, 0, 0, 20'h0, 20'h0, 1);
    cyc(1, 1, 0, 0, 20'h00aaa, 20'h00bbb, 0);
    repeat (10) cyc(0, 0, 0, 0, 20'($urandom), 20'($urandom), 0);
    repeat (400) cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     20'($urandom), 20'($urandom), $urandom_range(0, 59) == 0);
    repeat (3) cyc(0, 0, 0, 0, 20'h0, 20'h0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
